// File: rtl/int_lpc_ctrl.sv
// Per-frame sequencer: LSP interpolation, two LSP_to_Az passes and the Aq copies.
// Optional state update (LSP_NEW -> LSP_OLD) is built when INT_LPC_UPDATE_EN is defined.

module int_lpc_ctrl #(
    parameter logic [6:0] LSP_IN_ADDR  = 7'd0,
    parameter logic [6:0] AZ_OUT_ADDR  = 7'd64,
    parameter logic [6:0] LSP_OLD_ADDR = 7'd32,
    parameter logic [6:0] LSP_NEW_ADDR = 7'd48,
    parameter logic [6:0] AQ_ADDR      = 7'd96
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    output logic        done,
    output logic        az_start,
    input  logic        az_done,
    input  logic [6:0]  az_mem_read_addr,
    input  logic [6:0]  az_mem_write_addr,
    input  logic [31:0] az_mem_out,
    input  logic        az_mem_write_en,
    output logic [31:0] az_mem_in,
    output logic [6:0]  scratch_mem_read_addr,
    output logic [6:0]  scratch_mem_write_addr,
    output logic [31:0] scratch_mem_out,
    output logic        scratch_mem_write_en,
    input  logic [31:0] scratch_mem_in,
    output logic [15:0] add_outa,
    output logic [15:0] add_outb,
    input  logic [15:0] add_in
);

    typedef enum logic [3:0] {
        S_IDLE, S_INTERP, S_AZ1_START, S_AZ1_WAIT, S_COPY1, S_LOAD,
        S_AZ2_START, S_AZ2_WAIT, S_COPY2, S_UPDATE, S_DONE
    } state_t;

    state_t      state_reg;
    logic [3:0]  index_reg;
    logic        phase_reg;
    logic [15:0] half_reg;
    logic        done_reg;
    logic        az_start_reg;

    logic [6:0]  idx7;
    logic        last_word;
    logic        last_coef;

    assign idx7      = {3'd0, index_reg};
    assign last_word = (index_reg == 4'd9);
    assign last_coef = (index_reg == 4'd10);

    assign done      = done_reg;
    assign az_start  = az_start_reg;
    assign az_mem_in = scratch_mem_in;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg    <= S_IDLE;
            index_reg    <= '0;
            phase_reg    <= 1'b0;
            half_reg     <= '0;
            done_reg     <= 1'b0;
            az_start_reg <= 1'b0;
        end else begin
            done_reg     <= 1'b0;
            az_start_reg <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (start) begin
                        state_reg <= S_INTERP;
                        index_reg <= '0;
                        phase_reg <= 1'b0;
                    end
                end
                // Phase A latches old/2; phase B sums it with new/2 and writes back.
                S_INTERP: begin
                    phase_reg <= ~phase_reg;
                    if (!phase_reg) begin
                        half_reg <= {scratch_mem_in[15], scratch_mem_in[15:1]};
                    end else if (last_word) begin
                        index_reg    <= '0;
                        state_reg    <= S_AZ1_START;
                        az_start_reg <= 1'b1;
                    end else begin
                        index_reg <= index_reg + 4'd1;
                    end
                end
                S_AZ1_START: state_reg <= S_AZ1_WAIT;
                S_AZ1_WAIT: begin
                    if (az_done) state_reg <= S_COPY1;
                end
                S_COPY1: begin
                    if (last_coef) begin
                        index_reg <= '0;
                        state_reg <= S_LOAD;
                    end else begin
                        index_reg <= index_reg + 4'd1;
                    end
                end
                S_LOAD: begin
                    if (last_word) begin
                        index_reg    <= '0;
                        state_reg    <= S_AZ2_START;
                        az_start_reg <= 1'b1;
                    end else begin
                        index_reg <= index_reg + 4'd1;
                    end
                end
                S_AZ2_START: state_reg <= S_AZ2_WAIT;
                S_AZ2_WAIT: begin
                    if (az_done) state_reg <= S_COPY2;
                end
                S_COPY2: begin
                    if (last_coef) begin
                        index_reg <= '0;
`ifdef INT_LPC_UPDATE_EN
                        state_reg <= S_UPDATE;
`else
                        state_reg <= S_DONE;
                        done_reg  <= 1'b1;
`endif
                    end else begin
                        index_reg <= index_reg + 4'd1;
                    end
                end
`ifdef INT_LPC_UPDATE_EN
                S_UPDATE: begin
                    if (last_word) begin
                        index_reg <= '0;
                        state_reg <= S_DONE;
                        done_reg  <= 1'b1;
                    end else begin
                        index_reg <= index_reg + 4'd1;
                    end
                end
`endif
                S_DONE:  state_reg <= S_IDLE;
                default: state_reg <= S_IDLE;
            endcase
        end
    end

    // Memory port: LSP_to_Az owns it only while we wait on it.
    always_comb begin
        scratch_mem_read_addr  = '0;
        scratch_mem_write_addr = '0;
        scratch_mem_out        = '0;
        scratch_mem_write_en   = 1'b0;
        add_outa               = '0;
        add_outb               = '0;
        case (state_reg)
            S_AZ1_WAIT, S_AZ2_WAIT: begin
                scratch_mem_read_addr  = az_mem_read_addr;
                scratch_mem_write_addr = az_mem_write_addr;
                scratch_mem_out        = az_mem_out;
                scratch_mem_write_en   = az_mem_write_en;
            end
            S_INTERP: begin
                if (!phase_reg) begin
                    scratch_mem_read_addr = LSP_OLD_ADDR + idx7;
                end else begin
                    scratch_mem_read_addr  = LSP_NEW_ADDR + idx7;
                    add_outa               = half_reg;
                    add_outb               = {scratch_mem_in[15], scratch_mem_in[15:1]};
                    scratch_mem_write_addr = LSP_IN_ADDR + idx7;
                    scratch_mem_out        = {{16{add_in[15]}}, add_in};
                    scratch_mem_write_en   = 1'b1;
                end
            end
            S_COPY1: begin
                scratch_mem_read_addr  = AZ_OUT_ADDR + idx7;
                scratch_mem_write_addr = AQ_ADDR + idx7;
                scratch_mem_out        = scratch_mem_in;
                scratch_mem_write_en   = 1'b1;
            end
            S_LOAD: begin
                scratch_mem_read_addr  = LSP_NEW_ADDR + idx7;
                scratch_mem_write_addr = LSP_IN_ADDR + idx7;
                scratch_mem_out        = scratch_mem_in;
                scratch_mem_write_en   = 1'b1;
            end
            S_COPY2: begin
                scratch_mem_read_addr  = AZ_OUT_ADDR + idx7;
                scratch_mem_write_addr = AQ_ADDR + 7'd11 + idx7;
                scratch_mem_out        = scratch_mem_in;
                scratch_mem_write_en   = 1'b1;
            end
            S_UPDATE: begin
                scratch_mem_read_addr  = LSP_NEW_ADDR + idx7;
                scratch_mem_write_addr = LSP_OLD_ADDR + idx7;
                scratch_mem_out        = scratch_mem_in;
                scratch_mem_write_en   = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_int_lpc_ctrl.sv
// Bench for int_lpc_ctrl: scratch memory, saturating adder and a stub LSP_to_Az,
// with a frame-level reference model of the expected memory image and timing.

module tb_int_lpc_ctrl;

`ifdef INT_LPC_UPDATE_EN
    localparam int UPD_CYC = 10;
`else
    localparam int UPD_CYC = 0;
`endif

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        done;
    logic        az_start;
    logic        az_done;
    logic [6:0]  az_mem_read_addr;
    logic [6:0]  az_mem_write_addr;
    logic [31:0] az_mem_out;
    logic        az_mem_write_en;
    logic [31:0] az_mem_in;
    logic [6:0]  scratch_mem_read_addr;
    logic [6:0]  scratch_mem_write_addr;
    logic [31:0] scratch_mem_out;
    logic        scratch_mem_write_en;
    logic [31:0] scratch_mem_in;
    logic [15:0] add_outa;
    logic [15:0] add_outb;
    logic [15:0] add_in;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] mem      [0:127];
    logic [31:0] ref_mem  [0:127];
    logic [31:0] init_mem [0:127];
    logic        load_req = 1'b0;

    int          stub_lat = 4;
    logic [3:0]  stub_cnt = 4'd0;
    logic [31:0] stub_pat = 32'd0;
    int          az_calls = 0;
    logic        stray_we = 1'b0;
    logic        stray_done = 1'b0;
    logic        stub_act;
    logic [3:0]  stub_j;

    always #5 clock = ~clock;

    int_lpc_ctrl dut (
        .clock                  (clock),
        .reset                  (reset),
        .start                  (start),
        .done                   (done),
        .az_start               (az_start),
        .az_done                (az_done),
        .az_mem_read_addr       (az_mem_read_addr),
        .az_mem_write_addr      (az_mem_write_addr),
        .az_mem_out             (az_mem_out),
        .az_mem_write_en        (az_mem_write_en),
        .az_mem_in              (az_mem_in),
        .scratch_mem_read_addr  (scratch_mem_read_addr),
        .scratch_mem_write_addr (scratch_mem_write_addr),
        .scratch_mem_out        (scratch_mem_out),
        .scratch_mem_write_en   (scratch_mem_write_en),
        .scratch_mem_in         (scratch_mem_in),
        .add_outa               (add_outa),
        .add_outb               (add_outb),
        .add_in                 (add_in)
    );

    function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [15:0] b);
        int s;
        s = int'($signed(a)) + int'($signed(b));
        if (s > 32767) s = 32767;
        if (s < -32768) s = -32768;
        return 16'(s);
    endfunction

    function automatic int floor_half(input int x);
        if (x >= 0) return x / 2;
        return -((1 - x) / 2);
    endfunction

    function automatic logic [31:0] interp_ref(input logic [31:0] o, input logic [31:0] n);
        int s;
        s = floor_half(int'($signed(o[15:0]))) + floor_half(int'($signed(n[15:0])));
        if (s > 32767) s = 32767;
        if (s < -32768) s = -32768;
        return 32'(s);
    endfunction

    // Stub A(z) pattern for the n-th LSP_to_Az call: 0xA0.., 0xB0.., then tagged by pair.
    function automatic logic [31:0] pat(input int n);
        logic [31:0] base;
        base = ((n % 2) != 0) ? 32'h000000B0 : 32'h000000A0;
        return (32'(n / 2) << 16) | base;
    endfunction

    assign scratch_mem_in = mem[scratch_mem_read_addr];
    assign add_in         = sat_add(add_outa, add_outb);

    assign stub_act          = (stub_cnt != 4'd0);
    assign stub_j            = 4'(stub_lat) - stub_cnt;
    assign az_mem_write_en   = stub_act | stray_we;
    assign az_mem_write_addr = stub_act ? (7'd64 + {3'd0, stub_j}) : 7'd120;
    assign az_mem_out        = stub_act ? (stub_pat + {28'd0, stub_j}) : 32'hDEADBEEF;
    assign az_mem_read_addr  = stub_act ? {3'd0, stub_j} : 7'd77;
    assign az_done           = (stub_cnt == 4'd1) | stray_done;

    // Memory plus stub: words below stub_lat go through the port, the rest are placed directly.
    always @(posedge clock) begin
        if (load_req) begin
            for (int i = 0; i < 128; i++) mem[i] <= init_mem[i];
        end else begin
            if (scratch_mem_write_en) mem[scratch_mem_write_addr] <= scratch_mem_out;
            if (az_start) begin
                for (int j = stub_lat; j < 11; j++) mem[64 + j] <= pat(az_calls) + 32'(j);
                stub_pat <= pat(az_calls);
                az_calls <= az_calls + 1;
                stub_cnt <= 4'(stub_lat);
            end else if (stub_cnt != 4'd0) begin
                stub_cnt <= stub_cnt - 4'd1;
            end
        end
    end

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check_value({tag, "_done"}, 32'(done), 32'd0);
        check_value({tag, "_az_start"}, 32'(az_start), 32'd0);
        check_value({tag, "_we"}, 32'(scratch_mem_write_en), 32'd0);
        check_value({tag, "_raddr"}, 32'(scratch_mem_read_addr), 32'd0);
        check_value({tag, "_waddr"}, 32'(scratch_mem_write_addr), 32'd0);
        check_value({tag, "_wdata"}, scratch_mem_out, 32'd0);
        check_value({tag, "_adda"}, 32'(add_outa), 32'd0);
        check_value({tag, "_addb"}, 32'(add_outb), 32'd0);
    endtask

    task automatic load_mem();
        for (int i = 0; i < 128; i++) init_mem[i] = ref_mem[i];
        @(negedge clock);
        load_req = 1'b1;
        @(negedge clock);
        load_req = 1'b0;
    endtask

    task automatic compare_mem();
        for (int i = 0; i < 128; i++) check_value($sformatf("mem[%0d]", i), mem[i], ref_mem[i]);
    endtask

    // Runs one frame; cycle c = 0 is the cycle right after the edge that samples start.
    task automatic run_frame(input int fid, input int lat, input bit strays, input int abort_c);
        int c0, done_c, w1s, cp1, ld, a2, w2s, cp2, t, seen_c;
        bit aborted;
        logic [31:0] interp_v [10];
        stub_lat = lat;
        c0       = az_calls;
        w1s      = 21;
        cp1      = 21 + lat;
        ld       = 32 + lat;
        a2       = 42 + lat;
        w2s      = 43 + lat;
        cp2      = 43 + 2 * lat;
        done_c   = 54 + 2 * lat + UPD_CYC;
        aborted  = 1'b0;
        seen_c   = -1;
        for (int i = 0; i < 10; i++) interp_v[i] = interp_ref(ref_mem[32 + i], ref_mem[48 + i]);

        @(negedge clock);
        start = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;

        for (int c = 0; c <= done_c + 2 && !aborted; c++) begin
            @(negedge clock);
            if (c == abort_c) begin
                reset = 1'b0;
                #1;
                check_idle_outputs("abort");
                aborted = 1'b1;
            end else begin
                if (done) seen_c = c;
                check_value($sformatf("done_c%0d", c), 32'(done), 32'(c == done_c));
                check_value($sformatf("az_start_c%0d", c), 32'(az_start), 32'((c == 20) || (c == a2)));
                if (c == 20) begin
                    for (int i = 0; i < 10; i++)
                        check_value($sformatf("interp[%0d]", i), mem[i], interp_v[i]);
                end
                if (c >= w1s && c < cp1) begin
                    t = c - w1s;
                    check_value("grant1_we", 32'(scratch_mem_write_en), 32'd1);
                    check_value("grant1_waddr", 32'(scratch_mem_write_addr), 32'(64 + t));
                    check_value("grant1_wdata", scratch_mem_out, pat(c0) + 32'(t));
                    check_value("grant1_raddr", 32'(scratch_mem_read_addr), 32'(t));
                end
                if (c >= w2s && c < cp2) begin
                    t = c - w2s;
                    check_value("grant2_waddr", 32'(scratch_mem_write_addr), 32'(64 + t));
                    check_value("grant2_wdata", scratch_mem_out, pat(c0 + 1) + 32'(t));
                    check_value("grant2_raddr", 32'(scratch_mem_read_addr), 32'(t));
                end
                if (strays && c == cp1 + 2)
                    check_value("copy1_waddr", 32'(scratch_mem_write_addr), 32'(96 + 2));
                if (strays) begin
                    start      = (c == w1s);
                    stray_we   = (c == cp1 + 2);
                    stray_done = (c == ld + 1);
                end
            end
        end
        start      = 1'b0;
        stray_we   = 1'b0;
        stray_done = 1'b0;

        for (int i = 0; i < 10; i++) ref_mem[i] = interp_v[i];
        if (aborted) begin
            for (int j = 0; j < 11; j++) ref_mem[64 + j] = pat(c0) + 32'(j);
            for (int j = 0; j < abort_c - cp1; j++) ref_mem[96 + j] = pat(c0) + 32'(j);
            check_value("az_calls_abort", 32'(az_calls), 32'(c0 + 1));
            @(negedge clock);
            @(negedge clock);
            reset = 1'b1;
            @(negedge clock);
        end else begin
            for (int i = 0; i < 10; i++) ref_mem[i] = ref_mem[48 + i];
            for (int j = 0; j < 11; j++) begin
                ref_mem[64 + j] = pat(c0 + 1) + 32'(j);
                ref_mem[96 + j] = pat(c0) + 32'(j);
                ref_mem[107 + j] = pat(c0 + 1) + 32'(j);
            end
            if (UPD_CYC != 0)
                for (int i = 0; i < 10; i++) ref_mem[32 + i] = ref_mem[48 + i];
            check_value("done_seen", 32'(seen_c), 32'(done_c));
            check_value("az_calls", 32'(az_calls), 32'(c0 + 2));
        end
        compare_mem();
        $display("frame %0d: lat=%0d aborted=%0d expected_done_cycle=%0d seen=%0d",
                 fid, lat, aborted, done_c, seen_c);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", n_errors);
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 128; i++) ref_mem[i] = $urandom();
        ref_mem[32] = 32'h0000778a;
        ref_mem[48] = 32'h000068ac;
        ref_mem[37] = 32'hfffff6e6;
        ref_mem[53] = 32'hffffd5a4;
        for (int i = 0; i < 128; i++) init_mem[i] = ref_mem[i];
        load_req = 1'b1;
        @(negedge clock);
        @(negedge clock);
        check_idle_outputs("reset");
        load_req = 1'b0;
        reset = 1'b1;
        @(negedge clock);

        // Directed values: mem[0] -> 0x0000701b, mem[5] -> 0xffffe645 after INTERP.
        run_frame(0, 4, 1'b1, -1);

        for (int i = 0; i < 10; i++) begin
            ref_mem[32 + i] = 32'h00007fff;
            ref_mem[48 + i] = 32'h00007fff;
        end
        load_mem();
        run_frame(1, 4, 1'b0, -1);

        // Reset lands in the fourth COPY1 cycle (lat=3 -> COPY1 starts at cycle 24).
        for (int i = 0; i < 128; i++) ref_mem[i] = $urandom();
        load_mem();
        run_frame(2, 3, 1'b0, 27);
        run_frame(3, 4, 1'b1, -1);

        for (int f = 4; f < 9; f++) begin
            for (int i = 0; i < 128; i++) ref_mem[i] = $urandom();
            load_mem();
            run_frame(f, int'($urandom_range(1, 8)), 1'b1, -1);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
